reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port register file for the MIPS datapath: configurable read-port count, two write ports (ALU writeback and load writeback), optional hardwired-zero register 0, and optional same-cycle write-to-read bypass. A per-register busy scoreboard tracks outstanding load destinations. The full register image is exported for the debug path. It sits between the decode stage (reads and reservations) and the writeback stage (writes).

## Interface
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of combinational read ports (1..4).
- ZERO_REG, 1, 1: register 0 always reads 0, ignores writes, and is never busy.
- BYPASS, 1, 1: a read of an address being written this cycle returns the write data.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- clkEnable  input  1  qualifies every state update; low freezes all state.
- we0  input  1  write enable, port 0 (ALU writeback).
- addrW0  input  ADDR_WIDTH  write address, port 0.
- dataW0  input  DATA_WIDTH  write data, port 0.
- we1  input  1  write enable, port 1 (load writeback); has priority over port 0.
- addrW1  input  ADDR_WIDTH  write address, port 1.
- dataW1  input  DATA_WIDTH  write data, port 1.
- readAddr  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- readData  output  NUM_READ*DATA_WIDTH  packed read data, same packing as readAddr.
- readBusy  output  NUM_READ  busy bit of each read port's address, bypass-adjusted.
- reserveEn  input  1  mark reserveAddr busy (a load was issued).
- reserveAddr  input  ADDR_WIDTH  register to reserve.
- clearCollision  input  1  synchronous clear of the collision flag.
- busy  output  DEPTH  per-register busy bits; bit i is register i.
- collision  output  1  sticky: both ports wrote the same address in one enabled cycle.
- registers  output  DEPTH*DATA_WIDTH  flattened image; register 0 in the MSBs, register DEPTH-1 in the LSBs.

## Operation
- Write: at posedge clk with clkEnable=1, for each port with weN=1, bank[addrWN] <= dataWN. If both ports target the same address, port 1's data is stored. With ZERO_REG=1, writes to address 0 are discarded.
- Read: readData is combinational bank[readAddr]. With ZERO_REG=1, address 0 returns 0.
- Bypass (BYPASS=1): if clkEnable=1 and a write port targets the read address with its weN=1, readData returns the write data. Port 1 takes precedence over port 0. ZERO_REG overrides bypass for address 0. With BYPASS=0, the old contents are returned until the next cycle.
- Scoreboard: on an enabled edge, busy[addrWN] is cleared for each active write. busy[reserveAddr] is set when reserveEn=1. If a reserve and a write target the same address in one cycle, the reserve wins and the bit ends set. With ZERO_REG=1, busy[0] is held at 0.
- readBusy[k] = busy[readAddr_k], forced to 0 when BYPASS=1 and a same-cycle active write hits that address.
- Collision: on an enabled edge, collision is set when we0 & we1 & (addrW0==addrW1), excluding address 0 when ZERO_REG=1. clearCollision=1 clears it, and a new collision on the same edge wins. The flag is otherwise held.
- registers always reflects the stored bank contents (no bypass). With ZERO_REG=1, slot 0 reads as 0.

## Timing
- Reset (asynchronous, immediate): every register = 0, busy = 0, collision = 0. Consequently readData = 0, readBusy = 0, and registers = 0. While reset is high, writes and reserves are ignored. Reset mid-cycle takes effect without waiting for a clock edge.
- Write latency: 1 edge to the bank. Bypassed read latency: 0 (same cycle); unbypassed read latency: 1 cycle.
- Busy set latency: 1 edge after reserveEn. Busy clear latency: 1 edge after the write; with BYPASS=1 the clear appears on readBusy in the same cycle.
- clkEnable=0: no bank, busy or collision update, and bypass is disabled; reads show stored values.
- Reserve and write to the same address in one cycle: the stored data updates and busy ends set.

## Test plan
- Assert reset asynchronously between edges -> all outputs read 0 immediately. Writes of 0x1234 to r5 during reset are ignored (r5 still 0 after release).
- Drive we0=1, addrW0=3, dataW0=0xDEADBEEF, and readAddr port0=3 in the same cycle -> readData0=0xDEADBEEF that cycle with BYPASS=1. With BYPASS=0, readData0 shows the old value 0 that cycle and 0xDEADBEEF in the next.
- Write both ports to r7 (0x11, 0x22) -> r7=0x22 and collision=1. Then pulse clearCollision -> collision=0.
- Write 0xFFFF to r0 with ZERO_REG=1 -> readData=0, registers MSB slot = 0, busy[0] stays 0 after reserveAddr=0.
- Reserve r9 -> busy[9]=1 next cycle. Then we1 to r9 -> readBusy=0 in that cycle and busy[9]=0 after the edge. Reserve and write r9 in the same cycle -> busy[9] stays 1.
- Hold clkEnable=0 with active writes and reserves for 3 cycles -> no state change. Raise clkEnable -> the update happens on the first enabled edge.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write bypass, load busy scoreboard and collision flag.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clkEnable,
    input  logic                             we0,
    input  logic [ADDR_WIDTH-1:0]            addrW0,
    input  logic [DATA_WIDTH-1:0]            dataW0,
    input  logic                             we1,
    input  logic [ADDR_WIDTH-1:0]            addrW1,
    input  logic [DATA_WIDTH-1:0]            dataW1,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   readAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   readData,
    output logic [NUM_READ-1:0]              readBusy,
    input  logic                             reserveEn,
    input  logic [ADDR_WIDTH-1:0]            reserveAddr,
    input  logic                             clearCollision,
    output logic [2**ADDR_WIDTH-1:0]         busy,
    output logic                             collision,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] registers
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] bank [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic                  wz0;
    logic                  wz1;
    logic                  coll_now;
    logic                  byp_en;

    assign wz0      = we0 && !(ZERO_REG != 0 && addrW0 == '0);
    assign wz1      = we1 && !(ZERO_REG != 0 && addrW1 == '0);
    assign coll_now = wz0 && wz1 && addrW0 == addrW1;
    // Bypass only when an edge would really commit the write.
    assign byp_en   = BYPASS != 0 && clkEnable && !reset;
    assign busy     = busy_q;

    // Port 1 is applied last so it wins on a shared address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (clkEnable) begin
            if (wz0) bank[addrW0] <= dataW0;
            if (wz1) bank[addrW1] <= dataW1;
        end
    end

    // Reserve is applied after the clears so a same-cycle reserve leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[addrW0] = 1'b0;
        if (we1) busy_d[addrW1] = 1'b0;
        if (reserveEn) busy_d[reserveAddr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= '0;
            collision <= 1'b0;
        end else if (clkEnable) begin
            busy_q    <= busy_d;
            collision <= coll_now || (collision && !clearCollision);
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  h0;
        logic                  h1;
        assign ra = readAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign h0 = byp_en && we0 && addrW0 == ra;
        assign h1 = byp_en && we1 && addrW1 == ra;
        assign readData[k*DATA_WIDTH +: DATA_WIDTH] =
            (ZERO_REG != 0 && ra == '0) ? '0 : h1 ? dataW1 : h0 ? dataW0 : bank[ra];
        assign readBusy[k] = !(h0 || h1) && busy_q[ra];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_img
        assign registers[(DEPTH-1-i)*DATA_WIDTH +: DATA_WIDTH] =
            (ZERO_REG != 0 && i == 0) ? '0 : bank[i];
    end
endmodule
